// File: rtl/max7219_pkg.sv
// Shared frame format, MAX7219 register map and state encoding for the
// seven-segment serial transmit path.
package max7219_pkg;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } frame_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LO   = 3'd1,
      ST_HI   = 3'd2,
      ST_HOLD = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   localparam logic [7:0] NOOP   = 8'h00;
   localparam logic [7:0] DIGIT0 = 8'h01;
   localparam logic [7:0] DECODE = 8'h09;
   localparam logic [7:0] INTENS = 8'h0A;
   localparam logic [7:0] SCAN   = 8'h0B;
   localparam logic [7:0] SHDN   = 8'h0C;
   localparam logic [7:0] TEST   = 8'h0F;

   localparam frame_t FR_NORMAL_OP = '{addr: SHDN,   data: 8'h01};
   localparam frame_t FR_TEST_OFF  = '{addr: TEST,   data: 8'h00};
   localparam frame_t FR_NO_DECODE = '{addr: DECODE, data: 8'h00};
   localparam frame_t FR_SCAN_ALL  = '{addr: SCAN,   data: 8'h07};

   // Sequencer index map: 0..4 init frames, 5..12 digit registers 1..8.
   localparam logic [3:0] IDX_INIT_LAST   = 4'd4;
   localparam logic [3:0] IDX_DIGIT_FIRST = 4'd5;
   localparam logic [3:0] IDX_DIGIT_LAST  = 4'd12;

   function automatic frame_t init_frame(input logic [2:0] idx, input logic [3:0] intensity);
      frame_t f;
      case (idx)
         3'd0:    f = FR_NORMAL_OP;
         3'd1:    f = FR_TEST_OFF;
         3'd2:    f = FR_NO_DECODE;
         3'd3:    f = FR_SCAN_ALL;
         3'd4:    f = '{addr: INTENS, data: {4'h0, intensity}};
         default: f = '{addr: NOOP, data: 8'h00};
      endcase
      return f;
   endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// 16-bit MSB-first shift engine producing the MAX7219 DIN/CLK/LOAD waveform,
// one frame per start, with a done pulse on the last GAP cycle.
module spi_frame_tx
   import max7219_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_start,
   input  frame_t i_frame,
   output logic   o_sclk,
   output logic   o_mosi,
   output logic   o_cs_n,
   output logic   o_done,
   output logic   o_idle
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t      r_state;
   logic [7:0]  r_div_cnt;
   logic [3:0]  r_bit_cnt;
   logic [15:0] r_shift;
   logic        r_sclk;
   logic        r_mosi;
   logic        r_cs_n;

   state_t      w_state_next;
   logic [7:0]  w_div_next;
   logic [3:0]  w_bit_next;
   logic [15:0] w_shift_next;
   logic        w_phase_end;
   logic        w_done;

   assign w_phase_end = (r_div_cnt == DIV_LAST);

   always_comb begin
      w_state_next = r_state;
      w_div_next   = r_div_cnt;
      w_bit_next   = r_bit_cnt;
      w_shift_next = r_shift;
      w_done       = 1'b0;
      if (r_state != ST_IDLE) begin
         w_div_next = w_phase_end ? 8'd0 : r_div_cnt + 8'd1;
      end
      unique case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_next = ST_LO;
               w_shift_next = i_frame;
               w_bit_next   = 4'd15;
               w_div_next   = 8'd0;
            end
         end
         ST_LO: begin
            if (w_phase_end) w_state_next = ST_HI;
         end
         ST_HI: begin
            if (w_phase_end) begin
               if (r_bit_cnt == 4'd0) begin
                  w_state_next = ST_HOLD;
               end else begin
                  w_state_next = ST_LO;
                  w_bit_next   = r_bit_cnt - 4'd1;
                  w_shift_next = {r_shift[14:0], 1'b0};
               end
            end
         end
         ST_HOLD: begin
            if (w_phase_end) w_state_next = ST_GAP;
         end
         ST_GAP: begin
            if (w_phase_end) begin
               w_done = 1'b1;
               // Back-to-back frames skip IDLE so LOAD stays high for one phase only.
               if (i_start) begin
                  w_state_next = ST_LO;
                  w_shift_next = i_frame;
                  w_bit_next   = 4'd15;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_div_cnt <= 8'd0;
         r_bit_cnt <= 4'd0;
         r_shift   <= 16'd0;
         r_sclk    <= 1'b0;
         r_mosi    <= 1'b0;
         r_cs_n    <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_div_cnt <= w_div_next;
         r_bit_cnt <= w_bit_next;
         r_shift   <= w_shift_next;
         r_sclk    <= (w_state_next == ST_HI);
         r_mosi    <= ((w_state_next == ST_LO) || (w_state_next == ST_HI)) ? w_shift_next[15] : 1'b0;
         r_cs_n    <= (w_state_next == ST_IDLE) || (w_state_next == ST_GAP);
      end
   end

   assign o_sclk = r_sclk;
   assign o_mosi = r_mosi;
   assign o_cs_n = r_cs_n;
   assign o_done = w_done;
   assign o_idle = (r_state == ST_IDLE);

endmodule

// File: rtl/sseg_max7219_tx.sv
// MAX7219 driver: runs the power-up register sequence after reset, then
// rewrites all eight digit registers whenever new segment data is strobed.
module sseg_max7219_tx
   import max7219_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 4,
   parameter logic [3:0]  INTENSITY = 4'h8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] seg,
   input  logic        seg_vld,
   output logic        spi_sclk,
   output logic        spi_mosi,
   output logic        spi_cs_n,
   output logic        busy,
   output logic        init_done
);

   logic [3:0]  r_idx;
   logic        r_run;
   logic        r_init_done;
   logic        r_pend;
   logic [63:0] r_buf;
   logic [63:0] r_shadow;

   logic        w_start;
   logic [3:0]  w_start_idx;
   logic [3:0]  w_idx_next;
   logic        w_run_next;
   logic        w_copy;
   logic        w_init_end;
   logic        w_tx_done;
   logic        w_tx_idle;
   logic [63:0] w_src;
   frame_t      w_tab [0:15];

   // The shadow is loaded on the same edge a refresh starts, so its first
   // frame must come straight from the pending buffer.
   assign w_src = w_copy ? r_buf : r_shadow;

   for (genvar gi = 0; gi < 16; gi++) begin : g_tab
      if (gi <= 4) begin : g_init
         assign w_tab[gi] = init_frame(3'(gi), INTENSITY);
      end else if (gi <= 12) begin : g_digit
         assign w_tab[gi] = '{addr: DIGIT0 + 8'(gi - 5), data: w_src[(gi-5)*8 +: 8]};
      end else begin : g_pad
         assign w_tab[gi] = '{addr: NOOP, data: 8'h00};
      end
   end

   always_comb begin
      w_start     = 1'b0;
      w_start_idx = r_idx;
      w_idx_next  = r_idx;
      w_run_next  = r_run;
      w_copy      = 1'b0;
      w_init_end  = 1'b0;
      if (w_tx_idle) begin
         if (r_run) begin
            w_start = 1'b1;
         end else if (r_pend) begin
            w_start     = 1'b1;
            w_copy      = 1'b1;
            w_start_idx = IDX_DIGIT_FIRST;
            w_idx_next  = IDX_DIGIT_FIRST;
            w_run_next  = 1'b1;
         end
      end else if (w_tx_done) begin
         if ((r_idx == IDX_INIT_LAST) || (r_idx == IDX_DIGIT_LAST)) begin
            w_init_end = (r_idx == IDX_INIT_LAST);
            if (r_pend) begin
               w_start     = 1'b1;
               w_copy      = 1'b1;
               w_start_idx = IDX_DIGIT_FIRST;
               w_idx_next  = IDX_DIGIT_FIRST;
            end else begin
               w_run_next = 1'b0;
            end
         end else begin
            w_start     = 1'b1;
            w_start_idx = r_idx + 4'd1;
            w_idx_next  = r_idx + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx       <= 4'd0;
         r_run       <= 1'b1;
         r_init_done <= 1'b0;
         r_pend      <= 1'b0;
         r_buf       <= 64'd0;
         r_shadow    <= 64'd0;
      end else begin
         r_idx <= w_idx_next;
         r_run <= w_run_next;
         if (w_init_end) r_init_done <= 1'b1;
         if (w_copy) begin
            r_shadow <= r_buf;
            r_pend   <= 1'b0;
         end
         // A strobe on the copy cycle re-arms pending with the newer data.
         if (seg_vld) begin
            r_buf  <= seg;
            r_pend <= 1'b1;
         end
      end
   end

   spi_frame_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_start),
      .i_frame (w_tab[w_start_idx]),
      .o_sclk  (spi_sclk),
      .o_mosi  (spi_mosi),
      .o_cs_n  (spi_cs_n),
      .o_done  (w_tx_done),
      .o_idle  (w_tx_idle)
   );

   assign busy      = r_run | r_pend;
   assign init_done = r_init_done;

endmodule

// File: tb/tb_sseg_max7219_tx.sv
// Directed bench for sseg_max7219_tx: a serial monitor decodes every frame
// and checks it against a queue filled when the stimulus is driven.
module tb_sseg_max7219_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, rst1, vld0, vld1;
   logic [63:0] seg0, seg1;
   logic        sclk0, mosi0, cs0, busy0, idone0;
   logic        sclk1, mosi1, cs1, busy1, idone1;

   sseg_max7219_tx #(.CLK_DIV(2), .INTENSITY(4'h8)) u_dut (
      .clk(clk), .rst(rst0), .seg(seg0), .seg_vld(vld0),
      .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_cs_n(cs0),
      .busy(busy0), .init_done(idone0)
   );

   sseg_max7219_tx #(.CLK_DIV(1), .INTENSITY(4'h8)) u_dut1 (
      .clk(clk), .rst(rst1), .seg(seg1), .seg_vld(vld1),
      .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_cs_n(cs1),
      .busy(busy1), .init_done(idone1)
   );

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   logic [15:0] q0 [$];
   logic [15:0] q1 [$];
   int          nfall [2];
   int          nbits [2];
   int          fall_t [2];
   int          rise_t [2];
   logic [15:0] sh [2];
   logic        prev_cs [2];
   logic        prev_sclk [2];
   logic        idle_seen [2];
   logic        in_frame [2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push_init(input int k);
      logic [15:0] f [5];
      f = '{16'h0C01, 16'h0F00, 16'h0900, 16'h0B07, 16'h0A08};
      for (int i = 0; i < 5; i++) begin
         if (k == 0) q0.push_back(f[i]);
         else        q1.push_back(f[i]);
      end
   endtask

   task automatic push_refresh(input int k, input logic [63:0] s);
      for (int d = 0; d < 8; d++) begin
         logic [15:0] f;
         f[15:8] = 8'(d + 1);
         f[7:0]  = s[d*8 +: 8];
         if (k == 0) q0.push_back(f);
         else        q1.push_back(f);
      end
   endtask

   // Serial monitor for both instances, sampling on the falling clock edge.
   initial begin
      for (int k = 0; k < 2; k++) begin
         nfall[k] = 0; nbits[k] = 0; fall_t[k] = 0; rise_t[k] = 0; sh[k] = '0;
         prev_cs[k] = 1'b1; prev_sclk[k] = 1'b0; idle_seen[k] = 1'b1; in_frame[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int k = 0; k < 2; k++) begin
            logic        c, s, m, b, r;
            int          ph;
            logic [15:0] expf;
            c  = (k == 0) ? cs0   : cs1;
            s  = (k == 0) ? sclk0 : sclk1;
            m  = (k == 0) ? mosi0 : mosi1;
            b  = (k == 0) ? busy0 : busy1;
            r  = (k == 0) ? rst0  : rst1;
            ph = (k == 0) ? 2 : 1;
            if (r) begin
               nbits[k] = 0; idle_seen[k] = 1'b1; in_frame[k] = 1'b0;
            end else begin
               if (!b) idle_seen[k] = 1'b1;
               if (prev_cs[k] && !c) begin
                  if (!idle_seen[k]) check($sformatf("gap_len%0d", k), 64'(cyc - rise_t[k]), 64'(ph));
                  fall_t[k] = cyc; nfall[k]++; nbits[k] = 0; in_frame[k] = 1'b1;
               end
               if (!prev_sclk[k] && s && !c) begin
                  sh[k] = {sh[k][14:0], m};
                  nbits[k]++;
               end
               if (!prev_cs[k] && c && in_frame[k]) begin
                  check($sformatf("cs_low_len%0d", k), 64'(cyc - fall_t[k]), 64'(33 * ph));
                  check($sformatf("bit_count%0d", k), 64'(nbits[k]), 64'd16);
                  expf = 16'hxxxx;
                  if (k == 0 && q0.size() > 0) expf = q0.pop_front();
                  if (k == 1 && q1.size() > 0) expf = q1.pop_front();
                  check($sformatf("frame%0d", k), {48'd0, sh[k]}, {48'd0, expf});
                  rise_t[k] = cyc; idle_seen[k] = 1'b0; in_frame[k] = 1'b0;
               end
            end
            prev_cs[k]   = c;
            prev_sclk[k] = s;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t0, base;
      rst0 = 1'b1; rst1 = 1'b1; vld0 = 1'b0; vld1 = 1'b0; seg0 = '0; seg1 = '0;
      repeat (3) step();
      check("rst_sclk",  sclk0,  1'b0);
      check("rst_mosi",  mosi0,  1'b0);
      check("rst_cs_n",  cs0,    1'b1);
      check("rst_busy",  busy0,  1'b1);
      check("rst_idone", idone0, 1'b0);
      check("rst1_cs_n", cs1,    1'b1);
      check("rst1_busy", busy1,  1'b1);
      push_init(0); push_init(1);
      rst0 = 1'b0; rst1 = 1'b0;
      $display("[TB] init sequence, CLK_DIV=2 and CLK_DIV=1");

      n = 0; while (!idone0 && n < 2000) begin step(); n++; end
      check("init_wait", 64'(n < 2000), 64'd1);
      check("init_busy", busy0, 1'b0);
      check("init_frames", 64'(nfall[0]), 64'd5);
      check("init_end_t", 64'(cyc - rise_t[0]), 64'd2);
      check("init_q", 64'(q0.size()), 64'd0);

      n = 0; while (!idone1 && n < 2000) begin step(); n++; end
      check("init1_wait", 64'(n < 2000), 64'd1);
      check("init1_busy", busy1, 1'b0);

      $display("[TB] refresh, CLK_DIV=1");
      seg1 = 64'h0123_4567_89ab_cdef; push_refresh(1, seg1);
      vld1 = 1'b1; step(); vld1 = 1'b0;
      check("ref1_busy", busy1, 1'b1);
      base = nfall[1]; n = 0;
      while (nfall[1] == base && n < 100) begin step(); n++; end
      t0 = fall_t[1];
      n = 0; while (busy1 && n < 2000) begin step(); n++; end
      check("ref1_len", 64'(cyc - t0), 64'(8 * 34));
      check("ref1_q", 64'(q1.size()), 64'd0);

      $display("[TB] refresh, CLK_DIV=2");
      seg0 = 64'h7e30_6d79_335b_5f70; push_refresh(0, seg0);
      vld0 = 1'b1; step(); vld0 = 1'b0;
      check("ref_busy", busy0, 1'b1);
      base = nfall[0]; n = 0;
      while (nfall[0] == base && n < 100) begin step(); n++; end
      t0 = fall_t[0];
      n = 0; while (busy0 && n < 2000) begin step(); n++; end
      check("ref_len", 64'(cyc - t0), 64'(8 * 68));
      check("ref_q", 64'(q0.size()), 64'd0);

      $display("[TB] strobes A then B during a refresh");
      seg0 = 64'h1111_2222_3333_4444; push_refresh(0, seg0);
      vld0 = 1'b1; step(); vld0 = 1'b0;
      base = nfall[0];
      n = 0; while (nfall[0] != base + 3 && n < 2000) begin step(); n++; end
      seg0 = 64'hdead_beef_0bad_f00d;
      vld0 = 1'b1; step(); vld0 = 1'b0;
      n = 0; while (nfall[0] != base + 5 && n < 2000) begin step(); n++; end
      seg0 = 64'h0102_0408_1020_4080; push_refresh(0, seg0);
      vld0 = 1'b1; step(); vld0 = 1'b0;
      n = 0; while (busy0 && n < 3000) begin step(); n++; end
      check("ab_wait", 64'(n < 3000), 64'd1);
      check("ab_frames", 64'(nfall[0] - base), 64'd16);
      repeat (100) step();
      check("ab_no_extra", 64'(nfall[0] - base), 64'd16);
      check("ab_q", 64'(q0.size()), 64'd0);

      $display("[TB] strobe during init frame 2");
      rst0 = 1'b1; step(); step();
      push_init(0); rst0 = 1'b0;
      base = nfall[0];
      n = 0; while (nfall[0] != base + 3 && n < 2000) begin step(); n++; end
      seg0 = 64'h5a5a_a5a5_0ff0_f00f; push_refresh(0, seg0);
      vld0 = 1'b1; step(); vld0 = 1'b0;
      n = 0; while (!idone0 && n < 2000) begin step(); n++; end
      check("pi_wait", 64'(n < 2000), 64'd1);
      check("pi_busy", busy0, 1'b1);
      check("pi_end_t", 64'(cyc - rise_t[0]), 64'd2);
      n = 0; while (busy0 && n < 2000) begin step(); n++; end
      check("pi_frames", 64'(nfall[0] - base), 64'd13);
      check("pi_q", 64'(q0.size()), 64'd0);

      $display("[TB] reset during bit 7 of the digit-3 frame");
      seg0 = 64'h8081_8283_8485_8687; push_refresh(0, seg0);
      vld0 = 1'b1; step(); vld0 = 1'b0;
      base = nfall[0];
      n = 0; while (!(nfall[0] == base + 4 && nbits[0] == 7) && n < 3000) begin step(); n++; end
      seg0 = 64'hffff_0000_ffff_0000;
      vld0 = 1'b1; step(); vld0 = 1'b0;
      n = 0; while (!(nbits[0] == 8 && !sclk0) && n < 100) begin step(); n++; end
      check("ab7_wait", 64'(n < 100), 64'd1);
      rst0 = 1'b1; step();
      check("ab7_cs_n",  cs0,    1'b1);
      check("ab7_sclk",  sclk0,  1'b0);
      check("ab7_mosi",  mosi0,  1'b0);
      check("ab7_busy",  busy0,  1'b1);
      check("ab7_idone", idone0, 1'b0);
      q0.delete(); push_init(0);
      rst0 = 1'b0; base = nfall[0];
      n = 0; while (!idone0 && n < 2000) begin step(); n++; end
      repeat (200) step();
      check("ab7_busy_end", busy0, 1'b0);
      check("ab7_frames", 64'(nfall[0] - base), 64'd5);
      check("ab7_q", 64'(q0.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sseg_max7219_tx.md
Name: sseg_max7219_tx

Overview:
- Transmit end of the seven-segment path: drives a MAX7219 8-digit LED controller over its 3-wire serial interface (DIN/CLK/LOAD).
- Takes the 64-bit packed segment vector from the hex-to-segment decoder and writes each byte to one digit register in no-decode mode.
- Runs the chip's power-up register sequence after every reset, then refreshes all 8 digits each time new segment data is presented.

Parameters:
- CLK_DIV, 4: clk cycles per serial half-bit phase; legal range 1..255.
- INTENSITY, 4'h8: value written to the intensity register during init.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- seg  in  64  packed segments; byte d (seg[d*8+:8]) = digit d; bit7=DP, bit6..0 = a..g
- seg_vld  in  1  single-cycle strobe: seg is valid, request a refresh
- spi_sclk  out  1  serial clock to MAX7219 CLK
- spi_mosi  out  1  serial data to MAX7219 DIN, MSB first
- spi_cs_n  out  1  MAX7219 LOAD; low during a frame, rising edge latches the frame
- busy  out  1  high while an init or refresh sequence is in progress
- init_done  out  1  high once the init sequence has completed since the last reset

Behaviour:
- Reset values: spi_sclk=0, spi_mosi=0, spi_cs_n=1, busy=1, init_done=0. Pending request and buffers are cleared.
- rst asserted mid-frame aborts on the next edge and forces the reset values. Init restarts on the first cycle with rst low.
- Frame = 16 bits {addr[7:0], data[7:0]}, MSB first.
- Frame timing, with phase length P = CLK_DIV cycles:
  - For each of the 16 bits: LO phase (sclk=0, mosi=bit, cs_n=0) for P, then HI phase (sclk=1, mosi held) for P.
  - After bit 0: HOLD phase (sclk=0, cs_n=0) for P, then GAP phase (cs_n=1, sclk=0, mosi=0) for P.
  - Total frame length = 34*P cycles. cs_n falls on the first LO cycle.
- FSM states: IDLE, LO, HI, HOLD, GAP.
  - Sequencer index 0..12: 0-4 are init frames, 5-12 are digit frames.
  - Leaving GAP advances the index, or goes to IDLE at the end of a sequence.
- Init sequence, frames sent in order: 0x0C01 (normal op), 0x0F00 (test off), 0x0900 (no decode), 0x0B07 (scan 8 digits), 0x0A0 concatenated with INTENSITY.
  - init_done rises, and busy falls, on the cycle after the last GAP, unless a refresh is pending.
- Refresh sequence: 8 frames with address 0x01..0x08. Address k carries seg byte k-1, i.e. digit 0 goes to register 1.
- seg is captured into the pending buffer on seg_vld in any non-reset cycle; the pending flag is set.
- Refresh starts from IDLE the cycle after pending is seen. The buffer is copied to the shadow register and pending is cleared at that cycle; frames use only the shadow.
- seg_vld during init or refresh: the current sequence completes unchanged, then a refresh starts directly with no IDLE cycle. Multiple strobes collapse; the last one wins.
- busy=1 from reset through sequence end, and whenever a sequence is active. In IDLE with no pending request, busy=0.
- Counters: div_cnt is 8 bits and wraps at CLK_DIV-1; bit_cnt is 4 bits, 15 down to 0. No other arithmetic.

Decomposition:
- Package max7219_pkg:
  - frame_t typedef (struct: addr byte, data byte).
  - Register address localparams: NOOP, DIGIT0, DECODE, INTENS, SCAN, SHDN, TEST.
  - Init frame constants.
  - state_t enum.
- Sub-module spi_frame_tx holds the 16-bit shift engine and LO/HI/HOLD/GAP timing.
  - Interface: start/frame in, done pulse out.
  - The parent owns the sequencer, buffers, busy and init_done.

Test Plan:
- Reset then idle, CLK_DIV=2 -> sampling mosi on sclk rise yields 0x0C01, 0x0F00, 0x0900, 0x0B07, 0x0A08; each frame is 68 cycles; init_done=1 and busy=0 after the 5th GAP.
- After init, seg = 64'h7e30_6d79_335b_5f70 with a seg_vld pulse -> frames 0x0170, 0x025f, 0x035b, 0x0433, 0x0579, 0x066d, 0x0730, 0x087e; busy high for 8*68 cycles.
- seg_vld with value A at digit frame 3, then value B at frame 5 -> current refresh unchanged; exactly one further refresh carrying B starts with no IDLE cycle; A is never sent.
- seg_vld during init frame 2 -> init completes; refresh begins immediately; init_done rises at the init end.
- rst high during bit 7 of the digit-3 frame -> next cycle cs_n=1, sclk=0, mosi=0, busy=1, init_done=0; pending dropped; init resends from 0x0C01.
- CLK_DIV=1 -> each frame is 34 cycles; cs_n high for exactly 1 cycle between frames; sclk toggles every cycle during bits.
